forwarding_controller: RTL and testbench

// - Hazard/forwarding scheduler for the dual-issue pipeline: lane B (ALU/branch) and lane M (load/store).
// - Tracks in-flight destination registers of both lanes through EX, MEM and WB.
// - Drives the 3-bit select of the four ID-stage operand forwarding muxes (B.rs1, B.rs2, M.rs1, M.rs2).
// - Raises a one-cycle load-use stall. Counts stall cycles for performance monitoring.

---
 rtl/fwd_pkg.sv | 30 +++
 rtl/fwd_sel_resolve.sv | 34 +++
 rtl/forwarding_controller.sv | 105 ++++++++++
 tb/tb_forwarding_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types for the dual-issue forwarding controller: select encodings,
// tracked stage entries and the common match rule.
package fwd_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        FWD_RF    = 3'b000,
        FWD_B_EX  = 3'b001,
        FWD_M_EX  = 3'b010,
        FWD_B_MEM = 3'b011,
        FWD_M_MEM = 3'b100,
        FWD_B_WB  = 3'b101,
        FWD_M_WB  = 3'b110
    } fwd_sel_e;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              load;
    } stage_entry_t;

    // x0 is hard-wired zero, so it never matches an in-flight producer
    function automatic logic entry_hit(stage_entry_t e, logic [REG_AW-1:0] src);
        return (src != '0) && e.v && e.we && (e.rd == src);
    endfunction

endpackage

// File: rtl/fwd_sel_resolve.sv
// Per-operand forwarding priority resolver: youngest stage first, and lane M
// before lane B inside a stage.
module fwd_sel_resolve
    import fwd_pkg::*;
(
    input  logic [REG_AW-1:0] i_src,
    input  stage_entry_t      i_b_ex,
    input  stage_entry_t      i_m_ex,
    input  stage_entry_t      i_b_mem,
    input  stage_entry_t      i_m_mem,
    input  stage_entry_t      i_b_wb,
    input  stage_entry_t      i_m_wb,
    output fwd_sel_e          o_sel
);

    // A load in EX has no data yet; the stall covers that case instead
    always_comb begin
        o_sel = FWD_RF;
        if (entry_hit(i_m_ex, i_src) && !i_m_ex.load) begin
            o_sel = FWD_M_EX;
        end else if (entry_hit(i_b_ex, i_src)) begin
            o_sel = FWD_B_EX;
        end else if (entry_hit(i_m_mem, i_src)) begin
            o_sel = FWD_M_MEM;
        end else if (entry_hit(i_b_mem, i_src)) begin
            o_sel = FWD_B_MEM;
        end else if (entry_hit(i_m_wb, i_src)) begin
            o_sel = FWD_M_WB;
        end else if (entry_hit(i_b_wb, i_src)) begin
            o_sel = FWD_B_WB;
        end
    end

endmodule

// File: rtl/forwarding_controller.sv
// Hazard/forwarding scheduler for the B (ALU/branch) and M (load/store) lanes:
// tracks EX/MEM/WB destinations, drives operand forwarding selects and load-use stall.
module forwarding_controller
    import fwd_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_b_rs1,
    input  logic [REG_AW-1:0] id_b_rs2,
    input  logic [REG_AW-1:0] id_b_rd,
    input  logic              id_b_we,
    input  logic [REG_AW-1:0] id_m_rs1,
    input  logic [REG_AW-1:0] id_m_rs2,
    input  logic [REG_AW-1:0] id_m_rd,
    input  logic              id_m_we,
    input  logic              id_m_load,
    input  logic              flush,
    output logic [SEL_W-1:0]  fwd_b_rs1,
    output logic [SEL_W-1:0]  fwd_b_rs2,
    output logic [SEL_W-1:0]  fwd_m_rs1,
    output logic [SEL_W-1:0]  fwd_m_rs2,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_entry_t r_b_ex, r_m_ex, r_b_mem, r_m_mem, r_b_wb, r_m_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    fwd_sel_e w_sel_b_rs1, w_sel_b_rs2, w_sel_m_rs1, w_sel_m_rs2;
    logic     w_load_use;
    logic     w_accept;

    fwd_sel_resolve u_res_b_rs1 (.i_src(id_b_rs1), .i_b_ex(r_b_ex), .i_m_ex(r_m_ex),
        .i_b_mem(r_b_mem), .i_m_mem(r_m_mem), .i_b_wb(r_b_wb), .i_m_wb(r_m_wb), .o_sel(w_sel_b_rs1));
    fwd_sel_resolve u_res_b_rs2 (.i_src(id_b_rs2), .i_b_ex(r_b_ex), .i_m_ex(r_m_ex),
        .i_b_mem(r_b_mem), .i_m_mem(r_m_mem), .i_b_wb(r_b_wb), .i_m_wb(r_m_wb), .o_sel(w_sel_b_rs2));
    fwd_sel_resolve u_res_m_rs1 (.i_src(id_m_rs1), .i_b_ex(r_b_ex), .i_m_ex(r_m_ex),
        .i_b_mem(r_b_mem), .i_m_mem(r_m_mem), .i_b_wb(r_b_wb), .i_m_wb(r_m_wb), .o_sel(w_sel_m_rs1));
    fwd_sel_resolve u_res_m_rs2 (.i_src(id_m_rs2), .i_b_ex(r_b_ex), .i_m_ex(r_m_ex),
        .i_b_mem(r_b_mem), .i_m_mem(r_m_mem), .i_b_wb(r_b_wb), .i_m_wb(r_m_wb), .o_sel(w_sel_m_rs2));

    // Only lane M carries loads, so only M_EX can create a load-use hazard
    always_comb begin
        w_load_use = r_m_ex.load && (entry_hit(r_m_ex, id_b_rs1) || entry_hit(r_m_ex, id_b_rs2) ||
                                     entry_hit(r_m_ex, id_m_rs1) || entry_hit(r_m_ex, id_m_rs2));
        stall      = id_valid && !flush && w_load_use;
        w_accept   = id_valid && !stall && !flush;
    end

    always_comb begin
        fwd_b_rs1 = FWD_RF;
        fwd_b_rs2 = FWD_RF;
        fwd_m_rs1 = FWD_RF;
        fwd_m_rs2 = FWD_RF;
        if (id_valid) begin
            fwd_b_rs1 = w_sel_b_rs1;
            fwd_b_rs2 = w_sel_b_rs2;
            fwd_m_rs1 = w_sel_m_rs1;
            fwd_m_rs2 = w_sel_m_rs2;
        end
    end

    // Pipeline advance: EX takes the ID packet or a bubble, older stages shift
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_ex  <= '0;
            r_m_ex  <= '0;
            r_b_mem <= '0;
            r_m_mem <= '0;
            r_b_wb  <= '0;
            r_m_wb  <= '0;
        end else begin
            r_b_wb  <= r_b_mem;
            r_m_wb  <= r_m_mem;
            r_b_mem <= r_b_ex;
            r_m_mem <= r_m_ex;
            if (w_accept) begin
                r_b_ex <= '{v: 1'b1, rd: id_b_rd, we: id_b_we, load: 1'b0};
                r_m_ex <= '{v: 1'b1, rd: id_m_rd, we: id_m_we, load: id_m_load};
            end else begin
                r_b_ex <= '0;
                r_m_ex <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

    // The decoder splits packets where lane M reads lane B's destination
    a_no_intra_raw: assert property (@(posedge clk) disable iff (rst)
        !(id_valid && id_b_we && (id_b_rd != '0) &&
          ((id_m_rs1 == id_b_rd) || (id_m_rs2 == id_b_rd))));

endmodule

// File: tb/tb_forwarding_controller.sv
// Directed bench for forwarding_controller with a packet-history model and
// literal spot checks; a narrow-counter instance exercises saturation.
module tb_forwarding_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_b_rs1, id_b_rs2, id_b_rd, id_m_rs1, id_m_rs2, id_m_rd;
    logic       id_b_we, id_m_we, id_m_load, flush;
    logic [2:0] fwd_b_rs1, fwd_b_rs2, fwd_m_rs1, fwd_m_rs2;
    logic       stall;
    logic [31:0] stall_cnt;
    logic [2:0] s_b_rs1, s_b_rs2, s_m_rs1, s_m_rs2;
    logic       s_stall;
    logic [2:0] s_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forwarding_controller #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_b_rs1(id_b_rs1), .id_b_rs2(id_b_rs2), .id_b_rd(id_b_rd), .id_b_we(id_b_we),
        .id_m_rs1(id_m_rs1), .id_m_rs2(id_m_rs2), .id_m_rd(id_m_rd), .id_m_we(id_m_we),
        .id_m_load(id_m_load), .flush(flush),
        .fwd_b_rs1(fwd_b_rs1), .fwd_b_rs2(fwd_b_rs2), .fwd_m_rs1(fwd_m_rs1), .fwd_m_rs2(fwd_m_rs2),
        .stall(stall), .stall_cnt(stall_cnt));

    forwarding_controller #(.CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_b_rs1(id_b_rs1), .id_b_rs2(id_b_rs2), .id_b_rd(id_b_rd), .id_b_we(id_b_we),
        .id_m_rs1(id_m_rs1), .id_m_rs2(id_m_rs2), .id_m_rd(id_m_rd), .id_m_we(id_m_we),
        .id_m_load(id_m_load), .flush(flush),
        .fwd_b_rs1(s_b_rs1), .fwd_b_rs2(s_b_rs2), .fwd_m_rs1(s_m_rs1), .fwd_m_rs2(s_m_rs2),
        .stall(s_stall), .stall_cnt(s_cnt));

    // Model: history of accepted packets indexed by age (0=EX, 1=MEM, 2=WB)
    typedef struct packed {
        bit         v;
        logic [4:0] b_rd;
        bit         b_we;
        logic [4:0] m_rd;
        bit         m_we;
        bit         m_load;
    } pkt_t;

    pkt_t hist [3];
    int   m_cnt;

    function automatic logic [2:0] model_sel(logic [4:0] src);
        if (!id_valid || src == 5'd0) return 3'd0;
        for (int age = 0; age < 3; age++) begin
            if (hist[age].v) begin
                if (hist[age].m_we && hist[age].m_rd == src && !(age == 0 && hist[age].m_load))
                    return 3'(2 * age + 2);
                if (hist[age].b_we && hist[age].b_rd == src)
                    return 3'(2 * age + 1);
            end
        end
        return 3'd0;
    endfunction

    function automatic bit model_stall();
        logic [4:0] srcs [4];
        if (!id_valid || flush) return 1'b0;
        if (!(hist[0].v && hist[0].m_we && hist[0].m_load)) return 1'b0;
        srcs[0] = id_b_rs1; srcs[1] = id_b_rs2; srcs[2] = id_m_rs1; srcs[3] = id_m_rs2;
        for (int i = 0; i < 4; i++)
            if (srcs[i] != 5'd0 && srcs[i] == hist[0].m_rd) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit st;
        pkt_t p;
        st = model_stall();
        if (rst) begin
            for (int i = 0; i < 3; i++) hist[i] = '0;
            m_cnt = 0;
        end else begin
            p = '0;
            if (id_valid && !st && !flush)
                p = '{v: 1'b1, b_rd: id_b_rd, b_we: id_b_we, m_rd: id_m_rd, m_we: id_m_we, m_load: id_m_load};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = p;
            if (st) m_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every falling edge
    always @(negedge clk) begin
        bit st;
        st = model_stall();
        chk("m_stall", 32'(stall), 32'(st));
        chk("m_cnt", stall_cnt, 32'(m_cnt));
        chk("m_cnt_sat", 32'(s_cnt), 32'((m_cnt > 7) ? 7 : m_cnt));
        if (!st) begin
            chk("m_b_rs1", 32'(fwd_b_rs1), 32'(model_sel(id_b_rs1)));
            chk("m_b_rs2", 32'(fwd_b_rs2), 32'(model_sel(id_b_rs2)));
            chk("m_m_rs1", 32'(fwd_m_rs1), 32'(model_sel(id_m_rs1)));
            chk("m_m_rs2", 32'(fwd_m_rs2), 32'(model_sel(id_m_rs2)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pkt(input logic v, input logic [4:0] brs1, brs2, brd, input logic bwe,
                       input logic [4:0] mrs1, mrs2, mrd, input logic mwe, mload, fl);
        id_valid = v;  id_b_rs1 = brs1; id_b_rs2 = brs2; id_b_rd = brd; id_b_we = bwe;
        id_m_rs1 = mrs1; id_m_rs2 = mrs2; id_m_rd = mrd; id_m_we = mwe; id_m_load = mload;
        flush = fl;
    endtask

    task automatic nop_pkt();
        pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        pkt(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        rst = 1'b0;

        // First packet after reset sees no forwarding
        pkt(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rst_b_rs1", 32'(fwd_b_rs1), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);

        // B writes x5, consumed from EX, MEM, WB
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("ex_m_rs1", 32'(fwd_m_rs1), 32'd1);
        step(); @(negedge clk); chk("mem_m_rs1", 32'(fwd_m_rs1), 32'd3);
        step(); @(negedge clk); chk("wb_m_rs1", 32'(fwd_m_rs1), 32'd5);
        step(); @(negedge clk); chk("gone_m_rs1", 32'(fwd_m_rs1), 32'd0);

        // Same-stage tie: M wins
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);
        step(); pkt(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("tie_b_rs2", 32'(fwd_b_rs2), 32'd2);

        // Load-use: one stall cycle then MEM forwarding
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
        step(); pkt(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("lu_stall", 32'(stall), 32'd1);
        step(); @(negedge clk);
        chk("lu_unstall", 32'(stall), 32'd0);
        chk("lu_b_rs1", 32'(fwd_b_rs1), 32'd4);
        chk("lu_cnt", stall_cnt, 32'd1);

        // Flush beats load-use; killed packet's x11 never forwards
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 1'b0);
        step(); pkt(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("fl_stall", 32'(stall), 32'd0);
        step(); pkt(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_killed_b_rs1", 32'(fwd_b_rs1), 32'd0);
        chk("fl_load_m_rs1", 32'(fwd_m_rs1), 32'd4);
        chk("fl_cnt", stall_cnt, 32'd1);

        // x0 never forwards
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        step(); nop_pkt();
        @(negedge clk);
        chk("x0_b_rs1", 32'(fwd_b_rs1), 32'd0);
        chk("x0_m_rs2", 32'(fwd_m_rs2), 32'd0);

        // id_valid=0 forces selects to 000
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(); pkt(1'b0, 5'd13, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("inv_b_rs1", 32'(fwd_b_rs1), 32'd0);

        // Eight more load-use stalls: narrow counter saturates at 7
        for (int k = 0; k < 8; k++) begin
            step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'(14 + k), 1'b1, 1'b1, 1'b0);
            step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'(14 + k), 5'd0, 1'b0, 1'b0, 1'b0);
            step();
        end
        @(negedge clk);
        chk("sat_cnt_narrow", 32'(s_cnt), 32'd7);
        chk("sat_cnt_wide", stall_cnt, 32'd9);

        // Reset mid-stall drops the stall on the next edge
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b0);
        step(); pkt(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk); chk("rst_mid_stall_pre", 32'(stall), 32'd1);
        step(); @(negedge clk);
        chk("rst_mid_stall_post", 32'(stall), 32'd0);
        chk("rst_mid_cnt", stall_cnt, 32'd0);
        step(); rst = 1'b0;
        repeat (2) step();

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
